// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns, one 32-bit column per clock.
// Optional macro MIX_INV_EN adds the inv_mode port and InvMixColumns preconditioning.
module mix_columns_seq (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    input  logic [127:0] in_state,
    output logic         in_ready,
`ifdef MIX_INV_EN
    input  logic         inv_mode,
`endif
    output logic         out_valid,
    output logic [127:0] out_state,
    input  logic         out_ready,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [3:0][31:0] work_q, work_d, res_q, res_d;
    logic [31:0]      raw, col_b;
    logic [7:0]       a0, a1, a2, a3, m0, m1, m2, m3;

    function automatic logic [7:0] mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Column 0 holds the most significant word, so column c sits at packed index 3-c.
    assign raw = work_q[2'd3 - col_q];

`ifdef MIX_INV_EN
    logic       mode_q, mode_d;
    logic [7:0] u, v;

    // Inverse preconditioning folds InvMixColumns into the forward matrix.
    always_comb begin
        u  = mul2(mul2(raw[31:24] ^ raw[15:8]));
        v  = mul2(mul2(raw[23:16] ^ raw[7:0]));
        a0 = raw[31:24] ^ (mode_q ? u : 8'h00);
        a1 = raw[23:16] ^ (mode_q ? v : 8'h00);
        a2 = raw[15:8]  ^ (mode_q ? u : 8'h00);
        a3 = raw[7:0]   ^ (mode_q ? v : 8'h00);
    end

    // Direction is captured with the state at accept and held for the whole operation.
    assign mode_d = (state_q == IDLE && in_valid) ? inv_mode : mode_q;

    // Latched direction register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) mode_q <= 1'b0;
        else        mode_q <= mode_d;
    end
`else
    assign {a0, a1, a2, a3} = raw;
`endif

    // Forward matrix; x3 is mul2(x) ^ x.
    always_comb begin
        m0    = mul2(a0);
        m1    = mul2(a1);
        m2    = mul2(a2);
        m3    = mul2(a3);
        col_b = {m0 ^ m1 ^ a1 ^ a2 ^ a3,
                 a0 ^ m1 ^ m2 ^ a2 ^ a3,
                 a0 ^ a1 ^ m2 ^ m3 ^ a3,
                 m0 ^ a0 ^ a1 ^ a2 ^ m3};
    end

    // Next-state logic: accept in IDLE, one column per cycle in COMPUTE, hold in DONE.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (in_valid) begin
                work_d  = in_state;
                col_d   = 2'd0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                res_d[2'd3 - col_q] = col_b;
                col_d   = (col_q == 2'd3) ? col_q : col_q + 2'd1;
                state_d = (col_q == 2'd3) ? DONE : COMPUTE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == COMPUTE);
    assign out_state = res_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: randomized self-checking bench against a GF(2^8) matrix model.
module tb_mix_columns_seq;
    logic         clk = 1'b0, n_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, inv_mode = 1'b0;
    logic [127:0] in_state = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;
    int           checks = 0, failures = 0;

    mix_columns_seq dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_state(in_state), .in_ready(in_ready),
`ifdef MIX_INV_EN
        .inv_mode(inv_mode),
`endif
        .out_valid(out_valid), .out_state(out_state), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input bit inv);
        logic [31:0]  base = inv ? 32'h0e0b0d09 : 32'h02030101;
        logic [127:0] res = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(base[31 - 8 * ((k - r + 4) % 4) -: 8], st[127 - 8 * (4 * c + k) -: 8]);
                res[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic accept(input logic [127:0] st, input bit mode);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1; in_state = st; inv_mode = mode;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (out_state !== 128'h0) begin failures++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known();
        int lat, bcnt;
        accept(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
        wait_done(lat, bcnt);
        checks += 2;
        if (lat !== 4) begin failures++; $display("FAIL known1_latency got=%0d exp=4", lat); end
        if (out_state !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            failures++; $display("FAIL known1_state got=%h exp=8e4da1bc9fdc589d01010101c6c6c6c6", out_state);
        end
        release_out();
        accept(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0);
        wait_done(lat, bcnt);
        checks += 3;
        if (bcnt !== 4) begin failures++; $display("FAIL known2_busy_cycles got=%0d exp=4", bcnt); end
        if (out_valid !== 1'b1) begin failures++; $display("FAIL known2_out_valid got=%b exp=1", out_valid); end
        if (out_state !== 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff) begin
            failures++; $display("FAIL known2_state got=%h exp=d5d5d7d64d7ebdf800000000ffffffff", out_state);
        end
        release_out();
    endtask

    task automatic test_random_fwd();
        int lat, bcnt;
        logic [127:0] st;
        for (int n = 0; n < 8; n++) begin
            st = rand128();
            accept(st, 1'b0);
            wait_done(lat, bcnt);
            checks += 2;
            if (lat !== 4) begin failures++; $display("FAIL rand_latency got=%0d exp=4", lat); end
            if (out_state !== model(st, 1'b0)) begin
                failures++; $display("FAIL rand_state got=%h exp=%h", out_state, model(st, 1'b0));
            end
            release_out();
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL rand_idle got=%b exp=1", in_ready); end
        end
    endtask

    task automatic test_hold();
        int lat, bcnt;
        logic [127:0] x = rand128(), y = rand128();
        accept(x, 1'b0);
        wait_done(lat, bcnt);
        in_valid = 1'b1; in_state = y;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks += 3;
            if (out_state !== model(x, 1'b0)) begin failures++; $display("FAIL hold_state got=%h exp=%h", out_state, model(x, 1'b0)); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid got=%b exp=1", out_valid); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_idle got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL hold_second_accept busy=%b exp=1", busy); end
        wait_done(lat, bcnt);
        checks++;
        if (out_state !== model(y, 1'b0)) begin failures++; $display("FAIL hold_second_state got=%h exp=%h", out_state, model(y, 1'b0)); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic [127:0] st = rand128();
        accept(st, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 n_rst = 1'b0;
        #1;
        checks += 4;
        if (out_state !== 128'h0) begin failures++; $display("FAIL rstmid_state got=%h exp=0", out_state); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        #1 n_rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_stay_idle in_ready=%b busy=%b exp=1/0", in_ready, busy);
        end
        st = rand128();
        accept(st, 1'b0);
        wait_done(lat, bcnt);
        checks++;
        if (out_state !== model(st, 1'b0)) begin failures++; $display("FAIL rstmid_next got=%h exp=%h", out_state, model(st, 1'b0)); end
        release_out();
    endtask

`ifdef MIX_INV_EN
    task automatic test_inverse();
        int lat, bcnt;
        logic [127:0] st;
        accept(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1);
        wait_done(lat, bcnt);
        checks++;
        if (out_state !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
            failures++; $display("FAIL inv_known got=%h exp=db135345f20a225c01010101c6c6c6c6", out_state);
        end
        release_out();
        for (int n = 0; n < 6; n++) begin
            st = rand128();
            accept(st, 1'b1);
            wait_done(lat, bcnt);
            checks += 2;
            if (lat !== 4) begin failures++; $display("FAIL inv_latency got=%0d exp=4", lat); end
            if (out_state !== model(st, 1'b1)) begin failures++; $display("FAIL inv_rand got=%h exp=%h", out_state, model(st, 1'b1)); end
            release_out();
        end
        inv_mode = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [127:0] q[$];
        int idx = 0, res = 0, last_acc = -1;
        bit will;
        for (int n = 0; n < 5; n++) q.push_back(rand128());
        out_ready = 1'b1; inv_mode = 1'b0;
        in_valid = 1'b1; in_state = q[0];
        will = in_ready;
        for (int cyc = 0; cyc < 100 && res < 5; cyc++) begin
            @(posedge clk); #1;
            if (will) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== 6) begin failures++; $display("FAIL b2b_interval got=%0d exp=6", cyc - last_acc); end
                end
                last_acc = cyc;
                idx++;
                if (idx < 5) in_state = q[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if (out_state !== model(q[res], 1'b0)) begin failures++; $display("FAIL b2b_state got=%h exp=%h", out_state, model(q[res], 1'b0)); end
                res++;
            end
            will = in_valid && in_ready;
        end
        checks++;
        if (res !== 5) begin failures++; $display("FAIL b2b_results got=%0d exp=5", res); end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_known();
        test_random_fwd();
        test_hold();
        test_reset_mid();
`ifdef MIX_INV_EN
        test_inverse();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
